alu4_slice_sequencer: RTL

- Initiator-side companion to the combinational 4-bit ALU slice; the slice's opposite end.
- Accepts WIDTH-bit operation requests over a valid/ready handshake.
- Drives one 4-bit nibble per cycle into the external slice, carrying between nibbles, and reassembles the result and flags.
- Returns the result on a valid/ready response channel.

---
 rtl/alu4_pkg.sv | 50 +++++
 rtl/alu4_nibble_mux.sv | 32 +++
 rtl/alu4_slice_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu4_pkg.sv
// alu4_pkg: shared encodings and helpers for the 4-bit slice sequencer.
// Rev 1.0
`default_nettype none

package alu4_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_ADC = 3'd5
  } req_op_e;

  typedef enum logic [1:0] {
    SLC_ADD = 2'd0,
    SLC_AND = 2'd1,
    SLC_OR  = 2'd2,
    SLC_XOR = 2'd3
  } slc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC);
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
    return op > OP_ADC;
  endfunction

  function automatic slc_op_e slc_op_of(input logic [2:0] op);
    slc_op_e f;
    case (op)
      OP_AND:  f = SLC_AND;
      OP_OR:   f = SLC_OR;
      OP_XOR:  f = SLC_XOR;
      default: f = SLC_ADD;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu4_nibble_mux.sv
// alu4_nibble_mux: picks nibble idx of A/B and merges the slice result into that lane.
// Rev 1.0
`default_nettype none

module alu4_nibble_mux #(
  parameter int WIDTH = 16,
  parameter int IDXW  = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] res_i,
  input  logic [IDXW-1:0]  idx_i,
  input  logic [3:0]       f_i,
  output logic [3:0]       a_nib_o,
  output logic [3:0]       b_nib_o,
  output logic [WIDTH-1:0] res_o
);

  logic [IDXW+1:0] lsb;

  assign lsb     = {idx_i, 2'b00};
  assign a_nib_o = a_i[lsb +: 4];
  assign b_nib_o = b_i[lsb +: 4];

  always_comb begin
    res_o            = res_i;
    res_o[lsb +: 4]  = f_i;
  end

endmodule

`default_nettype wire

// File: rtl/alu4_slice_sequencer.sv
// alu4_slice_sequencer: runs a WIDTH-bit op through an external 4-bit ALU slice, one nibble per cycle.
// Rev 1.0
`default_nettype none

module alu4_slice_sequencer
  import alu4_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_carry_o,
  output logic             rsp_zero_o,
  output logic             rsp_ovf_o,
  output logic             rsp_err_o,
  output logic [3:0]       slc_a_o,
  output logic [3:0]       slc_b_o,
  output logic [1:0]       slc_op_o,
  output logic             slc_cin_o,
  input  logic [3:0]       slc_f_i,
  input  logic             slc_cout_i
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d, err_q, err_d, cflag_q, cflag_d;

  logic [3:0]       a_nib, b_nib;
  logic [WIDTH-1:0] res_merged;
  logic             arith, done;

  alu4_nibble_mux #(.WIDTH(WIDTH), .IDXW(IDXW)) u_mux (
    .a_i     (a_q),
    .b_i     (b_q),
    .res_i   (result_q),
    .idx_i   (idx_q),
    .f_i     (slc_f_i),
    .a_nib_o (a_nib),
    .b_nib_o (b_nib),
    .res_o   (res_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      cflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
      cflag_q  <= cflag_d;
    end
  end

  assign arith = is_arith(op_q);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    op_d        = op_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    err_d       = err_q;
    cflag_d     = cflag_q;
    req_ready_o = 1'b0;
    slc_a_o     = 4'd0;
    slc_b_o     = 4'd0;
    slc_op_o    = 2'd0;
    slc_cin_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gate with rst_n so ready is low for the whole reset assertion.
        req_ready_o = rst_n;
        if (req_valid_i) begin
          a_d      = req_a_i;
          b_d      = (req_op_i == OP_SUB) ? ~req_b_i : req_b_i;
          op_d     = req_op_i;
          idx_d    = '0;
          result_d = '0;
          err_d    = is_reserved(req_op_i);
          carry_d  = (req_op_i == OP_SUB) ? 1'b1 :
                     (req_op_i == OP_ADC) ? cflag_q : 1'b0;
          state_d  = is_reserved(req_op_i) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        slc_a_o   = a_nib;
        slc_b_o   = b_nib;
        slc_op_o  = slc_op_of(op_q);
        slc_cin_o = arith & carry_q;
        result_d  = res_merged;
        if (arith) carry_d = slc_cout_i;
        idx_d     = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready_i) begin
          if (arith) cflag_d = carry_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response fields read as zero outside DONE so stale results never leak.
  assign done         = (state_q == ST_DONE);
  assign rsp_valid_o  = done;
  assign rsp_result_o = done ? result_q : '0;
  assign rsp_carry_o  = done & arith & carry_q;
  assign rsp_zero_o   = done & (result_q == '0);
  assign rsp_ovf_o    = done & arith & (a_q[WIDTH-1] == b_q[WIDTH-1])
                        & (result_q[WIDTH-1] != a_q[WIDTH-1]);
  assign rsp_err_o    = done & err_q;

endmodule

`default_nettype wire
